// File: rtl/cnn16_ctrl_pkg.sv
// Shared types and encodings for the CNN16 control unit: FSM states, opcodes,
// datapath bus sources and ALU operations.
package cnn16_ctrl_pkg;

  typedef enum logic [3:0] {
    IDLE, F_ADDR, F_INSTR, DECODE, O_ADDR, O_READ,
    X_READ, X_ALU, X_FMUL, X_WRITE, HALT
  } state_t;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDA  = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_STA  = 4'h3;
  localparam logic [3:0] OP_FMUL = 4'h4;
  localparam logic [3:0] OP_JMP  = 4'h5;
  localparam logic [3:0] OP_JZ   = 4'h6;
  localparam logic [3:0] OP_HLT  = 4'hF;

  localparam logic [3:0] BUS_DR  = 4'd0;
  localparam logic [3:0] BUS_AC  = 4'd1;
  localparam logic [3:0] BUS_PC  = 4'd3;
  localparam logic [3:0] BUS_MEM = 4'd4;

  localparam logic [3:0] ALU_PASSB = 4'h0;
  localparam logic [3:0] ALU_ADD   = 4'h1;

  // States that hold mem_req high and wait on mem_ready.
  function automatic logic is_access(input state_t s);
    return (s == F_INSTR) || (s == O_READ) || (s == X_READ) || (s == X_WRITE);
  endfunction

  function automatic logic is_illegal(input logic [3:0] op);
    return !((op <= OP_JZ) || (op == OP_HLT));
  endfunction

endpackage

// File: rtl/cnn16_wait_timer.sv
// Counts consecutive not-ready cycles of one memory access; timeout is a
// combinational pulse on the WAIT_LIMIT-th stalled cycle, counter clears otherwise.
module cnn16_wait_timer #(
  parameter int WAIT_LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic stall,
  output logic timeout
);

  logic [7:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= 8'd0;
    end else if (stall) begin
      cnt <= cnt + 8'd1;
    end else begin
      cnt <= 8'd0;
    end
  end

  assign timeout = stall && (cnt == 8'(WAIT_LIMIT - 1));

endmodule

// File: rtl/cnn16_control_unit.sv
// Multi-cycle fetch/decode/execute sequencer for the CNN16 datapath.
// Zero-wait: NOP 3, JMP/JZ 5, STA 6, LDA/ADD/FMUL 7 cycles; each mem_ready-low cycle adds one.
module cnn16_control_unit
  import cnn16_ctrl_pkg::*;
#(
  parameter int WAIT_LIMIT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] IR_Value,
  input  logic [15:0] AC_Value,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        AR_Load,
  output logic        PC_Load,
  output logic        PC_Inc,
  output logic        IR_Load,
  output logic        DR_Load,
  output logic        AC_Load,
  output logic        FPLOAD_Load,
  output logic        fp_mul_en,
  output logic [3:0]  bus_sel,
  output logic [3:0]  alu_sel,
  output logic        halted,
  output logic        illegal_op,
  output logic        bus_error
);

  state_t     state, state_n;
  logic [3:0] op_q;
  logic       timeout;

  cnn16_wait_timer #(.WAIT_LIMIT(WAIT_LIMIT)) u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .stall   (is_access(state) && !mem_ready),
    .timeout (timeout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      op_q       <= OP_NOP;
      illegal_op <= 1'b0;
      bus_error  <= 1'b0;
    end else begin
      state <= state_n;
      if (state == DECODE) begin
        op_q <= IR_Value[15:12];
        if (is_illegal(IR_Value[15:12])) illegal_op <= 1'b1;
      end
      if (timeout) bus_error <= 1'b1;
    end
  end

  always_comb begin
    state_n     = state;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    AR_Load     = 1'b0;
    PC_Load     = 1'b0;
    PC_Inc      = 1'b0;
    IR_Load     = 1'b0;
    DR_Load     = 1'b0;
    AC_Load     = 1'b0;
    FPLOAD_Load = 1'b0;
    fp_mul_en   = 1'b0;
    bus_sel     = BUS_DR;
    alu_sel     = ALU_PASSB;
    halted      = 1'b0;

    case (state)
      IDLE: if (start) state_n = F_ADDR;
      HALT: begin
        halted = 1'b1;
        // A bus timeout is fatal until reset.
        if (start && !bus_error) state_n = F_ADDR;
      end
      F_ADDR, O_ADDR: begin
        bus_sel = BUS_PC;
        AR_Load = 1'b1;
        state_n = (state == F_ADDR) ? F_INSTR : O_READ;
      end
      F_INSTR: begin
        mem_req = 1'b1;
        bus_sel = BUS_MEM;
        if (mem_ready) begin
          IR_Load = 1'b1;
          PC_Inc  = 1'b1;
          state_n = DECODE;
        end
      end
      DECODE: begin
        if (IR_Value[15:12] == OP_HLT) state_n = HALT;
        else if (IR_Value[15:12] >= OP_LDA && IR_Value[15:12] <= OP_JZ) state_n = O_ADDR;
        else state_n = F_ADDR;
      end
      O_READ: begin
        mem_req = 1'b1;
        bus_sel = BUS_MEM;
        if (mem_ready) begin
          state_n = F_ADDR;
          if (op_q == OP_JMP || (op_q == OP_JZ && AC_Value == 16'd0)) begin
            PC_Load = 1'b1;
          end else if (op_q == OP_JZ) begin
            PC_Inc = 1'b1;
          end else begin
            AR_Load = 1'b1;
            PC_Inc  = 1'b1;
            state_n = (op_q == OP_STA) ? X_WRITE : X_READ;
          end
        end
      end
      X_READ: begin
        mem_req = 1'b1;
        bus_sel = BUS_MEM;
        if (mem_ready) begin
          if (op_q == OP_FMUL) begin
            FPLOAD_Load = 1'b1;
            state_n     = X_FMUL;
          end else begin
            DR_Load = 1'b1;
            state_n = X_ALU;
          end
        end
      end
      X_ALU: begin
        AC_Load = 1'b1;
        alu_sel = (op_q == OP_ADD) ? ALU_ADD : ALU_PASSB;
        state_n = F_ADDR;
      end
      X_FMUL: begin
        fp_mul_en = 1'b1;
        state_n   = F_ADDR;
      end
      X_WRITE: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        bus_sel = BUS_AC;
        if (mem_ready) state_n = F_ADDR;
      end
      default: state_n = IDLE;
    endcase

    if (timeout) state_n = HALT;
  end

endmodule

// File: tb/tb_cnn16_control_unit.sv
// Drives the control unit with a behavioural datapath and memory; architectural
// effects are scoreboarded and cycle-level behaviour is checked at directed points.
module tb_cnn16_control_unit;

  localparam int EV_AC = 1, EV_PCLD = 2, EV_WR = 3, EV_FMUL = 4;

  logic        clk = 1'b0;
  logic        rst, start, mem_ready;
  logic [15:0] IR_Value, AC_Value;
  logic        mem_req, mem_we, AR_Load, PC_Load, PC_Inc, IR_Load, DR_Load, AC_Load;
  logic        FPLOAD_Load, fp_mul_en, halted, illegal_op, bus_error;
  logic [3:0]  bus_sel, alu_sel;

  cnn16_control_unit #(.WAIT_LIMIT(4)) dut (
    .clk(clk), .rst(rst), .start(start), .IR_Value(IR_Value), .AC_Value(AC_Value),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .AR_Load(AR_Load),
    .PC_Load(PC_Load), .PC_Inc(PC_Inc), .IR_Load(IR_Load), .DR_Load(DR_Load),
    .AC_Load(AC_Load), .FPLOAD_Load(FPLOAD_Load), .fp_mul_en(fp_mul_en),
    .bus_sel(bus_sel), .alu_sel(alu_sel), .halted(halted), .illegal_op(illegal_op),
    .bus_error(bus_error)
  );

  always #5 clk = ~clk;

  // Behavioural datapath and memory.
  logic [15:0] mem [0:4095];
  logic [11:0] pc, ar;
  logic [15:0] ir, ac, dr, fpr, bus, alu_res;
  int          acc_cnt, wr_wait;
  logic        force_low;
  logic [20:0] outs;

  assign IR_Value = ir;
  assign AC_Value = ac;
  assign alu_res  = (alu_sel == 4'h1) ? ac + dr : dr;
  assign mem_ready = !force_low && mem_req && (acc_cnt >= (mem_we ? wr_wait : 0));
  assign outs = {mem_req, mem_we, AR_Load, PC_Load, PC_Inc, IR_Load, DR_Load, AC_Load,
                 FPLOAD_Load, fp_mul_en, bus_sel, alu_sel, halted, illegal_op, bus_error};

  always_comb begin
    case (bus_sel)
      4'd0:    bus = dr;
      4'd1:    bus = ac;
      4'd3:    bus = {4'h0, pc};
      4'd4:    bus = mem[ar];
      default: bus = 16'hDEAD;
    endcase
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= 12'h0; ar <= 12'h0; ir <= 16'h0; ac <= 16'h0; dr <= 16'h0; fpr <= 16'h0;
      acc_cnt <= 0;
    end else begin
      if (AR_Load) ar <= bus[11:0];
      if (PC_Load) pc <= bus[11:0];
      else if (PC_Inc) pc <= pc + 12'd1;
      if (IR_Load) ir <= bus;
      if (DR_Load) dr <= bus;
      if (AC_Load) ac <= alu_res;
      if (FPLOAD_Load) fpr <= bus;
      if (mem_req && mem_we && mem_ready) mem[ar] <= bus;
      acc_cnt <= (mem_req && !mem_ready) ? acc_cnt + 1 : 0;
    end
  end

  // Scoreboard and checking.
  typedef struct {
    int          kind;
    logic [11:0] addr;
    logic [15:0] data;
  } ev_t;

  ev_t exp_q[$];
  int  n_assert, n_fail, cyc;
  int  we_cycles, we_ac_cycles, fmul_cycles, fpl_cycles;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_ev(input int kind, input logic [11:0] a, input logic [15:0] d);
    ev_t e;
    e.kind = kind; e.addr = a; e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic sb_pop(input string tag, input int kind, input logic [11:0] a,
                        input logic [15:0] d);
    ev_t e;
    n_assert++;
    assert (exp_q.size() != 0) else begin
      n_fail++;
      $error("FAIL sb_%s: observed unexpected event data %0h expected none", tag, d);
    end
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk({"sb_", tag, "_kind"}, 32'(kind), 32'(e.kind));
      chk({"sb_", tag, "_addr"}, 32'(a), 32'(e.addr));
      chk({"sb_", tag, "_data"}, 32'(d), 32'(e.data));
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (AC_Load) sb_pop("ac", EV_AC, 12'h0, alu_res);
      if (PC_Load) sb_pop("pcld", EV_PCLD, bus[11:0], 16'h0);
      if (FPLOAD_Load) fpl_cycles++;
      if (fp_mul_en) begin
        fmul_cycles++;
        sb_pop("fmul", EV_FMUL, 12'h0, fpr);
      end
      if (mem_req && mem_we) begin
        we_cycles++;
        if (bus_sel == 4'd1) we_ac_cycles++;
        if (mem_ready) sb_pop("wr", EV_WR, ar, bus);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  task automatic tick_to(input int n);
    while (cyc < n) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; force_low = 1'b0; wr_wait = 0;
    tick(); tick();
    rst = 1'b0;
    tick();
    we_cycles = 0; we_ac_cycles = 0; fmul_cycles = 0; fpl_cycles = 0;
  endtask

  task automatic go();
    cyc = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_halt(input string tag, input int budget);
    while (!halted && cyc < budget) tick();
    chk({tag, "_halted"}, 32'(halted), 32'd1);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 4096; i++) mem[i] = 16'h0;
  endtask

  initial begin
    n_assert = 0; n_fail = 0; cyc = 0;
    rst = 1'b1; start = 1'b0; force_low = 1'b0; wr_wait = 0;
    clear_mem();
    tick();
    chk("reset_outputs", 32'(outs), 32'd0);
    rst = 1'b0;
    tick(); tick();
    chk("idle_after_release", 32'(outs), 32'd0);

    // LDA 0x010; HLT
    clear_mem();
    mem[0] = 16'h1010; mem[1] = 16'h0010; mem[2] = 16'hF000; mem[12'h010] = 16'h1234;
    push_ev(EV_AC, 12'h0, 16'h1234);
    do_reset(); go();
    tick_to(6);
    chk("lda_c6_acload", 32'(AC_Load), 32'd0);
    tick_to(7);
    chk("lda_c7_acload", 32'(AC_Load), 32'd1);
    chk("lda_c7_alu", 32'(alu_sel), 32'h0);
    tick_to(8);
    chk("lda_pc", 32'(pc), 32'd2);
    chk("lda_refetch", 32'(AR_Load), 32'd1);
    wait_halt("lda", 40);
    chk("lda_cycles", 32'(cyc - 1), 32'd10);
    chk("lda_sb_empty", 32'(exp_q.size()), 32'd0);

    // ADD 0x030; JZ 0x040 with AC == 0 (taken) then AC == 5 (not taken)
    for (int k = 0; k < 2; k++) begin
      clear_mem();
      mem[0] = 16'h2030; mem[1] = 16'h0030; mem[2] = 16'h6000; mem[3] = 16'h0040;
      mem[4] = 16'hF000; mem[12'h040] = 16'hF000;
      mem[12'h030] = (k == 0) ? 16'h0000 : 16'h0005;
      push_ev(EV_AC, 12'h0, (k == 0) ? 16'h0000 : 16'h0005);
      if (k == 0) push_ev(EV_PCLD, 12'h040, 16'h0);
      do_reset(); go();
      tick_to(12);
      chk("jz_pcload", 32'(PC_Load), (k == 0) ? 32'd1 : 32'd0);
      chk("jz_pcinc", 32'(PC_Inc), (k == 0) ? 32'd0 : 32'd1);
      chk("jz_bus_mem", 32'(bus_sel), 32'd4);
      tick_to(13);
      chk("jz_next_pc", 32'(pc), (k == 0) ? 32'h040 : 32'd4);
      chk("jz_fetch_bus_pc", 32'(bus_sel), 32'd3);
      wait_halt("jz", 60);
      chk("jz_cycles", 32'(cyc - 1), 32'd15);
      chk("jz_sb_empty", 32'(exp_q.size()), 32'd0);
    end

    // LDA 0x010; STA 0x020 with three write wait cycles; HLT
    clear_mem();
    mem[0] = 16'h1010; mem[1] = 16'h0010; mem[2] = 16'h3020; mem[3] = 16'h0020;
    mem[4] = 16'hF000; mem[12'h010] = 16'hBEEF;
    push_ev(EV_AC, 12'h0, 16'hBEEF);
    push_ev(EV_WR, 12'h020, 16'hBEEF);
    do_reset();
    wr_wait = 3;
    go();
    wait_halt("sta", 60);
    chk("sta_cycles", 32'(cyc - 1), 32'd19);
    chk("sta_we_cycles", 32'(we_cycles), 32'd4);
    chk("sta_we_bus_ac", 32'(we_ac_cycles), 32'd4);
    chk("sta_mem", 32'(mem[12'h020]), 32'hBEEF);
    chk("sta_sb_empty", 32'(exp_q.size()), 32'd0);

    // FMUL 0x050; illegal 0x7; NOP; HLT
    clear_mem();
    mem[0] = 16'h4050; mem[1] = 16'h0050; mem[2] = 16'h7000; mem[3] = 16'h0000;
    mem[4] = 16'hF000; mem[12'h050] = 16'h3C00;
    push_ev(EV_FMUL, 12'h0, 16'h3C00);
    do_reset(); go();
    tick_to(9);
    chk("illegal_before", 32'(illegal_op), 32'd0);
    tick_to(11);
    chk("illegal_set", 32'(illegal_op), 32'd1);
    chk("illegal_fetch_cont", 32'(AR_Load), 32'd1);
    wait_halt("fmul", 60);
    chk("fmul_cycles_total", 32'(cyc - 1), 32'd16);
    chk("fmul_en_count", 32'(fmul_cycles), 32'd1);
    chk("fpload_count", 32'(fpl_cycles), 32'd1);
    chk("illegal_sticky", 32'(illegal_op), 32'd1);
    chk("fmul_sb_empty", 32'(exp_q.size()), 32'd0);
    do_reset();
    chk("illegal_cleared", 32'(illegal_op), 32'd0);

    // Memory never ready: timeout after four wait cycles
    clear_mem();
    do_reset();
    force_low = 1'b1;
    go();
    tick_to(5);
    chk("to_c5_req", 32'(mem_req), 32'd1);
    chk("to_c5_halted", 32'(halted), 32'd0);
    tick_to(6);
    chk("to_halted", 32'(halted), 32'd1);
    chk("to_bus_error", 32'(bus_error), 32'd1);
    chk("to_req_drop", 32'(mem_req), 32'd0);
    start = 1'b1;
    tick(); tick();
    start = 1'b0;
    chk("to_start_ignored", 32'(halted), 32'd1);
    chk("to_no_fetch", 32'(AR_Load), 32'd0);

    // Asynchronous reset in the middle of an access
    do_reset();
    force_low = 1'b1;
    go();
    tick_to(3);
    chk("arst_req_before", 32'(mem_req), 32'd1);
    #2 rst = 1'b1;
    #1 chk("arst_outputs", 32'(outs), 32'd0);
    tick();
    rst = 1'b0;
    force_low = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
